// File: rtl/mc_main_ctrl_pkg.sv
// mc_main_ctrl_pkg: shared multicycle MIPS controller types, select enums and opcodes
package mc_main_ctrl_pkg;
    typedef enum logic [3:0] {
        Fetch, Decode, MemAddr, MemRd, MemWrbck, MemWr,
        RRExec, RRWrbck, Beq, Jmp, RIExec, RIWrbck
    } state_type;
    typedef enum logic       {AddrPC, AddrALUout} mem_addr_sel_t;
    typedef enum logic [1:0] {PCPlus4, PCBranch, PCJmp} nxt_pc_sel_t;
    typedef enum logic       {SrcaPC, SrcaRs} alu_srca_sel_t;
    typedef enum logic [1:0] {SrcbRt, Four, SrcbImm, BeqImm} alu_srcb_sel_t;
    typedef enum logic [2:0] {ADD, ADDU, SUB, AND, OR, XOR, RR} ALUop_t;
    typedef enum logic       {WrRt, WrRd} wreg_dst_sel_t;
    typedef enum logic       {ALUout, MemData} wrbck_data_sel_t;
    localparam logic [5:0] OP_RR    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    function automatic logic is_ri(input logic [5:0] op);
        return op == OP_ADDI || op == OP_ADDIU || op == OP_ANDI || op == OP_ORI || op == OP_XORI;
    endfunction
endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: controller <-> datapath/memory bundle
// master = controller (drives selects/enables/state), slave = datapath (drives opcode/zero/mem_rdy)
interface mc_main_ctrl_if;
    import mc_main_ctrl_pkg::*;
    logic            [5:0] opcode;
    logic                  zero;
    logic                  mem_rdy;
    logic                  mem_req;
    logic                  mem_wr_en;
    mem_addr_sel_t         mem_addr_sel;
    logic                  ir_wr_en;
    logic                  pc_wr_en;
    nxt_pc_sel_t           nxt_pc_sel;
    alu_srca_sel_t         alu_srca_sel;
    alu_srcb_sel_t         alu_srcb_sel;
    ALUop_t                alu_op;
    logic                  imm_zext;
    logic                  reg_wr_en;
    wreg_dst_sel_t         wreg_dst_sel;
    wrbck_data_sel_t       wrbck_data_sel;
    logic                  illegal_op;
    logic                  instr_done;
    state_type             state;
    modport master (
        input  opcode, zero, mem_rdy,
        output mem_req, mem_wr_en, mem_addr_sel, ir_wr_en, pc_wr_en, nxt_pc_sel,
               alu_srca_sel, alu_srcb_sel, alu_op, imm_zext, reg_wr_en,
               wreg_dst_sel, wrbck_data_sel, illegal_op, instr_done, state
    );
    modport slave (
        output opcode, zero, mem_rdy,
        input  mem_req, mem_wr_en, mem_addr_sel, ir_wr_en, pc_wr_en, nxt_pc_sel,
               alu_srca_sel, alu_srcb_sel, alu_op, imm_zext, reg_wr_en,
               wreg_dst_sel, wrbck_data_sel, illegal_op, instr_done, state
    );
endinterface

// File: rtl/mc_main_ctrl_ri_aluop_dec.sv
// ri_aluop_dec: immediate-op opcode -> {alu_op, imm_zext}
// in: opcode; out: alu_op, imm_zext (logical immediates are zero-extended)
module ri_aluop_dec
    import mc_main_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ALUop_t     alu_op,
    output logic       imm_zext
);
    assign alu_op   = opcode == OP_ADDIU ? ADDU :
                      opcode == OP_ANDI  ? AND  :
                      opcode == OP_ORI   ? OR   :
                      opcode == OP_XORI  ? XOR  : ADD;
    assign imm_zext = opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI;
endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main control FSM with mem_req/mem_rdy stalls
// ports: clk, reset (sync, active-high), bus (master modport: opcode/zero/mem_rdy in, datapath controls + state out)
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_main_ctrl_if.master bus
);
    state_type       state_q, cur, nxt;
    ALUop_t          ri_op;
    logic            ri_zext;
    logic            mem_req, mem_wr_en, ir_wr_en, pc_wr_en, reg_wr_en, illegal_op, instr_done, imm_zext;
    mem_addr_sel_t   mem_addr_sel;
    nxt_pc_sel_t     nxt_pc_sel;
    alu_srca_sel_t   alu_srca_sel;
    alu_srcb_sel_t   alu_srcb_sel;
    ALUop_t          alu_op;
    wreg_dst_sel_t   wreg_dst_sel;
    wrbck_data_sel_t wrbck_data_sel;
    ri_aluop_dec u_ri_dec (.opcode(bus.opcode), .alu_op(ri_op), .imm_zext(ri_zext));
    always_ff @(posedge clk)
        state_q <= reset ? Fetch : nxt;
    // during reset the outputs show the Fetch decode regardless of the held state
    assign cur = reset ? Fetch : state_q;
    always_comb begin
        nxt            = Fetch;
        mem_req        = 1'b0;
        mem_wr_en      = 1'b0;
        mem_addr_sel   = AddrPC;
        ir_wr_en       = 1'b0;
        pc_wr_en       = 1'b0;
        nxt_pc_sel     = PCPlus4;
        alu_srca_sel   = SrcaPC;
        alu_srcb_sel   = SrcbRt;
        alu_op         = ADD;
        imm_zext       = 1'b0;
        reg_wr_en      = 1'b0;
        wreg_dst_sel   = WrRt;
        wrbck_data_sel = ALUout;
        illegal_op     = 1'b0;
        instr_done     = 1'b0;
        case (cur)
            Fetch: begin
                mem_req      = 1'b1;
                alu_srcb_sel = Four;
                ir_wr_en     = bus.mem_rdy;
                pc_wr_en     = bus.mem_rdy;
                nxt          = bus.mem_rdy ? Decode : Fetch;
            end
            Decode: begin
                alu_srcb_sel = BeqImm;
                nxt          = bus.opcode == OP_LW || bus.opcode == OP_SW ? MemAddr :
                               bus.opcode == OP_RR  ? RRExec :
                               bus.opcode == OP_BEQ ? Beq    :
                               bus.opcode == OP_J   ? Jmp    :
                               is_ri(bus.opcode)    ? RIExec : Fetch;
                illegal_op   = nxt == Fetch;
                instr_done   = nxt == Fetch;
            end
            MemAddr: begin
                alu_srca_sel = SrcaRs;
                alu_srcb_sel = SrcbImm;
                nxt          = bus.opcode == OP_SW ? MemWr : MemRd;
            end
            MemRd: begin
                mem_req      = 1'b1;
                mem_addr_sel = AddrALUout;
                nxt          = bus.mem_rdy ? MemWrbck : MemRd;
            end
            MemWrbck: begin
                reg_wr_en      = 1'b1;
                wrbck_data_sel = MemData;
                instr_done     = 1'b1;
            end
            MemWr: begin
                mem_req      = 1'b1;
                mem_wr_en    = 1'b1;
                mem_addr_sel = AddrALUout;
                instr_done   = bus.mem_rdy;
                nxt          = bus.mem_rdy ? Fetch : MemWr;
            end
            RRExec: begin
                alu_srca_sel = SrcaRs;
                alu_op       = RR;
                nxt          = RRWrbck;
            end
            RRWrbck: begin
                reg_wr_en    = 1'b1;
                wreg_dst_sel = WrRd;
                instr_done   = 1'b1;
            end
            Beq: begin
                alu_srca_sel = SrcaRs;
                alu_op       = SUB;
                nxt_pc_sel   = PCBranch;
                pc_wr_en     = bus.zero;
                instr_done   = 1'b1;
            end
            Jmp: begin
                nxt_pc_sel = PCJmp;
                pc_wr_en   = 1'b1;
                instr_done = 1'b1;
            end
            RIExec: begin
                alu_srca_sel = SrcaRs;
                alu_srcb_sel = SrcbImm;
                alu_op       = ri_op;
                imm_zext     = ri_zext;
                nxt          = RIWrbck;
            end
            RIWrbck: begin
                reg_wr_en  = 1'b1;
                instr_done = 1'b1;
            end
            default: nxt = Fetch;
        endcase
    end
    assign bus.mem_req        = mem_req & ~reset;
    assign bus.mem_wr_en      = mem_wr_en & ~reset;
    assign bus.ir_wr_en       = ir_wr_en & ~reset;
    assign bus.pc_wr_en       = pc_wr_en & ~reset;
    assign bus.reg_wr_en      = reg_wr_en & ~reset;
    assign bus.illegal_op     = illegal_op & ~reset;
    assign bus.instr_done     = instr_done & ~reset;
    assign bus.mem_addr_sel   = mem_addr_sel;
    assign bus.nxt_pc_sel     = nxt_pc_sel;
    assign bus.alu_srca_sel   = alu_srca_sel;
    assign bus.alu_srcb_sel   = alu_srcb_sel;
    assign bus.alu_op         = alu_op;
    assign bus.imm_zext       = imm_zext;
    assign bus.wreg_dst_sel   = wreg_dst_sel;
    assign bus.wrbck_data_sel = wrbck_data_sel;
    assign bus.state          = state_q;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: randomized instruction-level checks of mc_main_ctrl against a per-instruction model
module tb_mc_main_ctrl;
    import mc_main_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mc_main_ctrl_if bus();
    mc_main_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    int n_cyc, n_regw, n_req, n_wr, n_pcw, n_ill, n_ir;
    wreg_dst_sel_t   w_dst;
    wrbck_data_sel_t w_src;
    nxt_pc_sel_t     pc_sel_last;
    ALUop_t          ri_op;
    logic            ri_z;
    state_type       st [16];
    logic [5:0] legal [10] = '{OP_RR, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW};

    // Drives one instruction: f stall cycles in the fetch access, m in the data access
    // (data access starts 3 cycles after fetch completes); mem_rdy/zero are random where ignored.
    task automatic run_instr(input logic [5:0] op, input int f, input int m, input logic z);
        bit mem, done;
        mem = op == OP_LW || op == OP_SW;
        {n_regw, n_req, n_wr, n_pcw, n_ill, n_ir} = '0;
        n_cyc = -1;
        done = 0;
        bus.opcode = op;
        for (int p = 0; p < 64; p++) begin
            bus.mem_rdy = p < f ? 1'b0 : p == f ? 1'b1 : (mem && p >= f + 3) ? 1'(p >= f + 3 + m) : 1'($urandom);
            bus.zero    = p == f + 2 ? z : 1'($urandom);
            @(negedge clk);
            if (p < 16) st[p] = bus.state;
            n_regw += int'(bus.reg_wr_en);
            n_req  += int'(bus.mem_req);
            n_wr   += int'(bus.mem_wr_en);
            n_pcw  += int'(bus.pc_wr_en);
            n_ill  += int'(bus.illegal_op);
            n_ir   += int'(bus.ir_wr_en);
            if (bus.reg_wr_en) begin
                w_dst = bus.wreg_dst_sel;
                w_src = bus.wrbck_data_sel;
            end
            if (bus.pc_wr_en) pc_sel_last = bus.nxt_pc_sel;
            if (p == f + 2) begin
                ri_op = bus.alu_op;
                ri_z  = bus.imm_zext;
            end
            if (bus.instr_done) begin
                n_cyc = p + 1;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
    endtask

    task automatic test_instr(input logic [5:0] op, input int f, input int m, input logic z);
        bit is_lw, is_sw, is_rr, is_ri, is_beq, is_j, ill;
        int e_cyc, e_regw, e_req, e_wr, e_pcw;
        ALUop_t e_op;
        is_lw = op == OP_LW; is_sw = op == OP_SW; is_rr = op == OP_RR; is_beq = op == OP_BEQ; is_j = op == OP_J;
        is_ri = op == OP_ADDI || op == OP_ADDIU || op == OP_ANDI || op == OP_ORI || op == OP_XORI;
        ill = !(is_lw || is_sw || is_rr || is_ri || is_beq || is_j);
        e_cyc  = (is_lw ? 5 : (is_sw || is_rr || is_ri) ? 4 : (is_beq || is_j) ? 3 : 2) + f + ((is_lw || is_sw) ? m : 0);
        e_regw = (is_lw || is_rr || is_ri) ? 1 : 0;
        e_req  = f + 1 + ((is_lw || is_sw) ? m + 1 : 0);
        e_wr   = is_sw ? m + 1 : 0;
        e_pcw  = 1 + (is_j ? 1 : is_beq ? int'(z) : 0);
        run_instr(op, f, m, z);
        checks += 7;
        if (n_cyc !== e_cyc) begin errors++; $display("FAIL cycles op=%h f=%0d m=%0d got %0d exp %0d", op, f, m, n_cyc, e_cyc); end
        if (n_regw !== e_regw) begin errors++; $display("FAIL reg_wr_count op=%h got %0d exp %0d", op, n_regw, e_regw); end
        if (n_req !== e_req) begin errors++; $display("FAIL mem_req_count op=%h got %0d exp %0d", op, n_req, e_req); end
        if (n_wr !== e_wr) begin errors++; $display("FAIL mem_wr_count op=%h got %0d exp %0d", op, n_wr, e_wr); end
        if (n_pcw !== e_pcw) begin errors++; $display("FAIL pc_wr_count op=%h z=%0d got %0d exp %0d", op, z, n_pcw, e_pcw); end
        if (n_ill !== int'(ill)) begin errors++; $display("FAIL illegal_count op=%h got %0d exp %0d", op, n_ill, ill); end
        if (n_ir !== 1) begin errors++; $display("FAIL ir_wr_count op=%h got %0d exp 1", op, n_ir); end
        if (e_regw == 1) begin
            checks += 2;
            if (w_dst !== (is_rr ? WrRd : WrRt)) begin errors++; $display("FAIL wreg_dst op=%h got %0d", op, w_dst); end
            if (w_src !== (is_lw ? MemData : ALUout)) begin errors++; $display("FAIL wrbck_src op=%h got %0d", op, w_src); end
        end
        if (is_j || (is_beq && z)) begin
            checks++;
            if (pc_sel_last !== (is_j ? PCJmp : PCBranch)) begin errors++; $display("FAIL nxt_pc_sel op=%h got %0d", op, pc_sel_last); end
        end
        if (is_ri) begin
            e_op = op == OP_ADDI ? ADD : op == OP_ADDIU ? ADDU : op == OP_ANDI ? AND : op == OP_ORI ? OR : XOR;
            checks += 2;
            if (ri_op !== e_op) begin errors++; $display("FAIL ri_alu_op op=%h got %0d exp %0d", op, ri_op, e_op); end
            if (ri_z !== (op == OP_ANDI || op == OP_ORI || op == OP_XORI)) begin errors++; $display("FAIL ri_zext op=%h got %0d", op, ri_z); end
        end
        checks++;
        if (bus.state !== Fetch) begin errors++; $display("FAIL back_to_fetch op=%h got %0d", op, bus.state); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'h3f;
        bus.mem_rdy = 1'b1;
        bus.zero = 1'b1;
        @(negedge clk);
        checks += 2;
        if ({bus.mem_req, bus.mem_wr_en, bus.ir_wr_en, bus.pc_wr_en, bus.reg_wr_en, bus.illegal_op, bus.instr_done} !== 7'b0) begin
            errors++; $display("FAIL reset_enables got %b exp 0", {bus.mem_req, bus.mem_wr_en, bus.ir_wr_en, bus.pc_wr_en, bus.reg_wr_en, bus.illegal_op, bus.instr_done});
        end
        if (bus.alu_srcb_sel !== Four) begin errors++; $display("FAIL reset_fetch_decode srcb got %0d exp %0d", bus.alu_srcb_sel, Four); end
        @(negedge clk);
        checks++;
        if (bus.state !== Fetch) begin errors++; $display("FAIL reset_state got %0d exp %0d", bus.state, Fetch); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.opcode = OP_LW;
        bus.mem_rdy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== MemRd || bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_memrd state=%0d req=%b exp %0d/1", bus.state, bus.mem_req, MemRd); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_gate req=%b regw=%b exp 0/0", bus.mem_req, bus.reg_wr_en); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.state !== Fetch) begin errors++; $display("FAIL mid_reset_state got %0d exp %0d", bus.state, Fetch); end
        if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_regw got %b exp 0", bus.reg_wr_en); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        state_type e [5] = '{Fetch, Decode, MemAddr, MemRd, MemWrbck};
        test_instr(OP_LW, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (st[i] !== e[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, st[i], e[i]); end
        end
    endtask

    task automatic test_sw_stall();
        test_instr(OP_SW, 0, 3, 1'b0);
        checks++;
        if (st[3] !== MemWr || st[6] !== MemWr) begin errors++; $display("FAIL sw_hold states %0d/%0d exp %0d", st[3], st[6], MemWr); end
    endtask

    task automatic test_beq();
        test_instr(OP_BEQ, 0, 0, 1'b1);
        test_instr(OP_BEQ, 1, 0, 1'b0);
    endtask

    task automatic test_imm();
        test_instr(OP_ORI, 0, 0, 1'b0);
        checks++;
        if (st[2] !== RIExec) begin errors++; $display("FAIL ori_state got %0d exp %0d", st[2], RIExec); end
        test_instr(OP_ADDI, 0, 0, 1'b0);
        test_instr(OP_ADDIU, 2, 0, 1'b0);
    endtask

    task automatic test_illegal();
        test_instr(6'h3f, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom); while (op inside {OP_RR, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW});
            end else op = legal[$urandom_range(0, 9)];
            test_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_lw();
        test_sw_stall();
        test_beq();
        test_imm();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
